serial_deserializer: RTL and testbench

//   Parametrised serial-in/parallel-out deserializer for the decoder receive path.
//   - Assembles WIDTH-bit words from a qualified serial bit stream.
//   - Supports frame re-alignment on frameSync.
//   - Buffers completed words in a DEPTH-entry FIFO behind a valid/ready handshake.
//   - Flags overrun when a completed word finds the FIFO full.
//   - Sits between the serial line receiver and the message decoder/consumer.
//

---
 rtl/serial_deserializer_if.sv | 31 +++
 rtl/serial_deserializer.sv | 185 ++++++++++++++++++
 tb/tb_serial_deserializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_deserializer_if.sv
// Bundle of serial-side and word-side signals of the deserializer.
// The slave modport is the deserializer; the master modport is the
// environment that drives the serial line and consumes words.
interface serial_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic             serialIn;
  logic             serialValid;
  logic             frameSync;
  logic [WIDTH-1:0] wordOut;
  logic             wordValid;
  logic             wordReady;
  logic [LW-1:0]    fifoLevel;
  logic [CW-1:0]    bitCount;
  logic             overrun;
  logic             clearOverrun;

  modport master (
    output serialIn, serialValid, frameSync, wordReady, clearOverrun,
    input  wordOut, wordValid, fifoLevel, bitCount, overrun
  );

  modport slave (
    input  serialIn, serialValid, frameSync, wordReady, clearOverrun,
    output wordOut, wordValid, fifoLevel, bitCount, overrun
  );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-in / parallel-out deserializer with frame re-alignment, a
// DEPTH-entry output FIFO behind a valid/ready handshake and a sticky
// overrun flag for words that complete while the FIFO is full.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input logic                  clock,
  input logic                  resetN,
  serial_deserializer_if.slave bus
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] LAST_CNT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIRST_POS = (LSB_FIRST != 0) ? CW'(0) : CW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == LAST_PTR) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             overrun_q, overrun_d;

  // Combinational helpers
  logic [CW-1:0]    pos_s;
  logic [WIDTH-1:0] assembled_s;
  logic             push_req_s;
  logic             pop_s;
  logic             full_s;
  logic             push_ok_s;
  logic             drop_s;

  // Bit slot for the bit arriving now, following the configured bit order.
  always_comb begin
    if (LSB_FIRST != 0) begin
      pos_s = bit_cnt_q;
    end else begin
      pos_s = LAST_CNT - bit_cnt_q;
    end
  end

  // Shift register and bit counter; frameSync overrides word completion.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    push_req_s  = 1'b0;
    assembled_s = shift_q;
    assembled_s[pos_s] = bus.serialIn;
    if (bus.frameSync) begin
      shift_d = {WIDTH{1'b0}};
      if (bus.serialValid) begin
        shift_d[FIRST_POS] = bus.serialIn;
        bit_cnt_d          = CW'(1);
      end else begin
        bit_cnt_d = {CW{1'b0}};
      end
    end else if (bus.serialValid) begin
      if (bit_cnt_q == LAST_CNT) begin
        push_req_s = 1'b1;
        shift_d    = {WIDTH{1'b0}};
        bit_cnt_d  = {CW{1'b0}};
      end else begin
        shift_d   = assembled_s;
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Handshake qualifiers: a push into a full FIFO still lands when the head
  // leaves on the same edge, because the write slot is the one being freed.
  always_comb begin
    pop_s     = word_valid_q & bus.wordReady;
    full_s    = (level_q == FULL_LVL);
    push_ok_s = push_req_s & (~full_s | pop_s);
    drop_s    = push_req_s & full_s & ~pop_s;
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = assembled_s;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Registered head word and valid; the head holds its last value when empty.
  always_comb begin
    word_valid_d = (level_d != {LW{1'b0}});
    if (word_valid_d) begin
      word_out_d = mem_d[rd_ptr_d];
    end else begin
      word_out_d = word_out_q;
    end
  end

  // Sticky overrun: a new drop wins over a simultaneous clear.
  always_comb begin
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (bus.clearOverrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      shift_q      <= {WIDTH{1'b0}};
      bit_cnt_q    <= {CW{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      level_q      <= {LW{1'b0}};
      word_out_q   <= {WIDTH{1'b0}};
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.wordOut   = word_out_q;
  assign bus.wordValid = word_valid_q;
  assign bus.fifoLevel = level_q;
  assign bus.bitCount  = bit_cnt_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: an LSB-first and an MSB-first
// instance share one stimulus stream; expected values are hand-computed.
module tb_serial_deserializer;

  logic clock;
  logic reset_n;
  logic serial_in;
  logic serial_valid;
  logic frame_sync;
  logic word_ready;
  logic clear_overrun;

  int checks = 0;
  int errors = 0;

  serial_deserializer_if #(.WIDTH(8), .DEPTH(4)) if_lsb ();
  serial_deserializer_if #(.WIDTH(8), .DEPTH(4)) if_msb ();

  assign if_lsb.serialIn     = serial_in;
  assign if_lsb.serialValid  = serial_valid;
  assign if_lsb.frameSync    = frame_sync;
  assign if_lsb.wordReady    = word_ready;
  assign if_lsb.clearOverrun = clear_overrun;
  assign if_msb.serialIn     = serial_in;
  assign if_msb.serialValid  = serial_valid;
  assign if_msb.frameSync    = frame_sync;
  assign if_msb.wordReady    = word_ready;
  assign if_msb.clearOverrun = clear_overrun;

  serial_deserializer #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1)) dut_lsb (
    .clock  (clock),
    .resetN (reset_n),
    .bus    (if_lsb.slave)
  );

  serial_deserializer #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(0)) dut_msb (
    .clock  (clock),
    .resetN (reset_n),
    .bus    (if_msb.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in    = b;
    serial_valid = 1'b1;
    cyc();
    serial_valid = 1'b0;
    serial_in    = 1'b0;
  endtask

  // Sends the first n bits of w, w[0] first.
  task automatic send_partial(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(w[i]);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    send_partial(w, 8);
  endtask

  task automatic pop_one();
    word_ready = 1'b1;
    cyc();
    word_ready = 1'b0;
  endtask

  logic [7:0] exp_seq [4];

  // Directed scenarios.
  initial begin
    reset_n       = 1'b0;
    serial_in     = 1'b0;
    serial_valid  = 1'b0;
    frame_sync    = 1'b0;
    word_ready    = 1'b0;
    clear_overrun = 1'b0;
    #2;
    check_eq("rst_valid",   32'(if_lsb.wordValid), 32'd0);
    check_eq("rst_level",   32'(if_lsb.fifoLevel), 32'd0);
    check_eq("rst_bitcnt",  32'(if_lsb.bitCount),  32'd0);
    check_eq("rst_overrun", 32'(if_lsb.overrun),   32'd0);
    check_eq("rst_word",    32'(if_lsb.wordOut),   32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // 1: bits 1,0,1,1,0,0,1,0 back to back
    send_partial(8'h4D, 7);
    check_eq("t1_bitcnt7", 32'(if_lsb.bitCount),  32'd7);
    check_eq("t1_novalid", 32'(if_lsb.wordValid), 32'd0);
    send_bit(1'b0);
    check_eq("t1_valid",   32'(if_lsb.wordValid), 32'd1);
    check_eq("t1_level",   32'(if_lsb.fifoLevel), 32'd1);
    check_eq("t1_word",    32'(if_lsb.wordOut),   32'h4D);
    check_eq("t1_wrap",    32'(if_lsb.bitCount),  32'd0);
    check_eq("t1_msb",     32'(if_msb.wordOut),   32'hB2);
    pop_one();
    check_eq("t1_popped",  32'(if_lsb.fifoLevel), 32'd0);
    check_eq("t1_empty",   32'(if_lsb.wordValid), 32'd0);

    // 2: same bits with idle gaps carrying junk on serialIn
    for (int i = 0; i < 8; i++) begin
      send_bit(8'h4D >> i);
      serial_in = ~serial_in;
      cyc();
      if (i == 3) begin
        check_eq("t2_hold", 32'(if_lsb.bitCount), 32'd4);
      end
    end
    check_eq("t2_word",  32'(if_lsb.wordOut),   32'h4D);
    check_eq("t2_msb",   32'(if_msb.wordOut),   32'hB2);
    check_eq("t2_level", 32'(if_lsb.fifoLevel), 32'd1);
    pop_one();

    // 3: frameSync after 5 bits restarts the word with the sync-cycle bit
    send_partial(8'h1F, 5);
    check_eq("t3_bitcnt5", 32'(if_lsb.bitCount), 32'd5);
    frame_sync = 1'b1;
    send_bit(1'b1);
    frame_sync = 1'b0;
    check_eq("t3_bitcnt1", 32'(if_lsb.bitCount),  32'd1);
    check_eq("t3_nopush",  32'(if_lsb.fifoLevel), 32'd0);
    send_partial(8'h00, 7);
    check_eq("t3_level",   32'(if_lsb.fifoLevel), 32'd1);
    check_eq("t3_word",    32'(if_lsb.wordOut),   32'h01);
    check_eq("t3_msb",     32'(if_msb.wordOut),   32'h80);
    cyc();
    cyc();
    check_eq("t3_stable",  32'(if_lsb.wordOut),   32'h01);
    pop_one();
    // frameSync on the completing bit: no push, new word starts
    send_partial(8'hFF, 7);
    frame_sync = 1'b1;
    send_bit(1'b0);
    frame_sync = 1'b0;
    check_eq("t3_syncwin", 32'(if_lsb.fifoLevel), 32'd0);
    check_eq("t3_synccnt", 32'(if_lsb.bitCount),  32'd1);
    frame_sync = 1'b1;
    cyc();
    frame_sync = 1'b0;
    check_eq("t3_syncidle", 32'(if_lsb.bitCount), 32'd0);

    // 4: overflow with wordReady low
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    send_word(8'h44);
    check_eq("t4_full",    32'(if_lsb.fifoLevel), 32'd4);
    check_eq("t4_noovr",   32'(if_lsb.overrun),   32'd0);
    send_word(8'h55);
    check_eq("t4_level",   32'(if_lsb.fifoLevel), 32'd4);
    check_eq("t4_overrun", 32'(if_lsb.overrun),   32'd1);
    check_eq("t4_head",    32'(if_lsb.wordOut),   32'h11);
    cyc();
    check_eq("t4_sticky",  32'(if_lsb.overrun),   32'd1);
    clear_overrun = 1'b1;
    cyc();
    clear_overrun = 1'b0;
    check_eq("t4_cleared", 32'(if_lsb.overrun),   32'd0);
    // clear and a new drop on the same edge: set wins
    send_partial(8'h77, 7);
    clear_overrun = 1'b1;
    send_bit(1'b0);
    clear_overrun = 1'b0;
    check_eq("t4_setwins", 32'(if_lsb.overrun),   32'd1);
    clear_overrun = 1'b1;
    cyc();
    clear_overrun = 1'b0;
    check_eq("t4_clr2",    32'(if_lsb.overrun),   32'd0);

    // 5: full FIFO, pop on the completing edge lets the push through
    send_partial(8'h66, 7);
    word_ready = 1'b1;
    send_bit(1'b0);
    word_ready = 1'b0;
    check_eq("t5_level",   32'(if_lsb.fifoLevel), 32'd4);
    check_eq("t5_noovr",   32'(if_lsb.overrun),   32'd0);
    exp_seq[0] = 8'h22;
    exp_seq[1] = 8'h33;
    exp_seq[2] = 8'h44;
    exp_seq[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5_order%0d", i), 32'(if_lsb.wordOut), 32'(exp_seq[i]));
      pop_one();
    end
    check_eq("t5_drained", 32'(if_lsb.fifoLevel), 32'd0);

    // 6: asynchronous reset mid-word with two words queued
    send_word(8'h12);
    send_word(8'h34);
    send_partial(8'hFF, 3);
    check_eq("t6_pre_lvl", 32'(if_lsb.fifoLevel), 32'd2);
    check_eq("t6_pre_cnt", 32'(if_lsb.bitCount),  32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_valid",   32'(if_lsb.wordValid), 32'd0);
    check_eq("t6_level",   32'(if_lsb.fifoLevel), 32'd0);
    check_eq("t6_bitcnt",  32'(if_lsb.bitCount),  32'd0);
    check_eq("t6_word",    32'(if_lsb.wordOut),   32'd0);
    cyc();
    reset_n = 1'b1;
    send_word(8'hA5);
    check_eq("t6_clean",   32'(if_lsb.wordOut),   32'hA5);
    check_eq("t6_lvl1",    32'(if_lsb.fifoLevel), 32'd1);
    check_eq("t6_msb",     32'(if_msb.wordOut),   32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
